// File: rtl/encoder16_4_arb.sv
// ---------------------------------------------------------------------------
// encoder16_4_arb
//
// Request encoder / arbiter in front of the NICNAC16 control unit. Up to 16
// request lines are latched into a pending vector. One pending request at a
// time is presented as a 4-bit index with a valid/acknowledge handshake.
// Selection is either fixed priority (highest index wins) or round robin
// (scan starts at a rotating pointer that moves past the last acked grant).
//
// Parameters:
//   ROUND_ROBIN  0 = fixed priority, 1 = rotating priority
//
// Ports:
//   CLK   in   1   clock, all state changes on the rising edge
//   RST   in   1   asynchronous active-high reset
//   R     in  16   request lines, R[i] pairs with decoder output Di
//   E     in   1   enable: gates request capture and new grants
//   ACK   in   1   consumer acknowledge of the presented index
//   A     out  4   index of the granted request
//   V     out  1   A is valid and held stable
//   PEND  out 16   registered pending-request vector
// ---------------------------------------------------------------------------
module encoder16_4_arb #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] R,
    input  logic        E,
    input  logic        ACK,
    output logic [3:0]  A,
    output logic        V,
    output logic [15:0] PEND
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pend;
    logic [15:0] w_pend_next;
    logic [15:0] w_req;
    logic [15:0] w_clr;
    logic [3:0]  r_a;
    logic [3:0]  w_a_next;
    logic [3:0]  r_ptr;
    logic [3:0]  w_ptr_next;
    logic [3:0]  w_win;
    logic        r_v;
    logic        w_v_next;
    logic        w_any;

    // Highest set index; an empty vector yields 0 but is never used because
    // a grant is only issued when something is pending.
    function automatic logic [3:0] f_fixed_pick(input logic [15:0] p);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (p[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Rotate the vector so the pointer position lands at bit 0, take the
    // lowest set bit of the rotated vector, then add the pointer back.
    // The 4-bit add gives the mod-16 wrap for free.
    function automatic logic [3:0] f_rr_pick(input logic [15:0] p,
                                             input logic [3:0]  ptr);
        logic [31:0] dbl;
        logic [15:0] rot;
        logic [3:0]  off;
        dbl = {p, p} >> ptr;
        rot = dbl[15:0];
        off = '0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) off = 4'(i);
        end
        return ptr + off;
    endfunction

    assign w_any = |r_pend;
    assign w_win = ROUND_ROBIN ? f_rr_pick(r_pend, r_ptr) : f_fixed_pick(r_pend);

    // Pending vector: clear the acked bit, then OR in new requests so that a
    // request on the acked line in the same cycle keeps it pending.
    always_comb begin
        w_clr = '0;
        if (r_state == S_BUSY && ACK) begin
            w_clr = 16'h0001 << r_a;
        end
        w_req       = R & {16{E}};
        w_pend_next = (r_pend & ~w_clr) | w_req;
    end

    // Grant FSM: IDLE selects from the registered pending vector, BUSY holds
    // the index until acknowledged. ACK in IDLE falls through untouched.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_v_next     = r_v;
        w_ptr_next   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (E && w_any) begin
                    w_a_next     = w_win;
                    w_v_next     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ACK) begin
                    w_v_next     = 1'b0;
                    w_state_next = S_IDLE;
                    if (ROUND_ROBIN) begin
                        w_ptr_next = r_a + 4'd1;
                    end
                end
            end
            default: begin
                w_v_next     = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_a     <= '0;
            r_v     <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_a     <= w_a_next;
            r_v     <= w_v_next;
            r_ptr   <= w_ptr_next;
        end
    end

    assign A    = r_a;
    assign V    = r_v;
    assign PEND = r_pend;

endmodule

// File: doc/encoder16_4_arb.md
Name: encoder16_4_arb

Overview:
- Inverse of the 4-to-16 decoder. Collects up to 16 request lines and latches each one as pending.
- Presents one pending request at a time as a 4-bit index with a valid/acknowledge handshake.
- Used as the interrupt/device-request encoder in front of the NICNAC16 control unit. The control unit consumes the index and acknowledges it.
- Supports fixed-priority and round-robin selection.

Parameters:
ROUND_ROBIN, 0, 0 = fixed priority (highest index wins); 1 = rotating priority starting at PTR.

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
R  in  16  request lines; R[i] corresponds to decoder output Di
E  in  1  enable; gates request capture and new grants
ACK  in  1  consumer acknowledge of the presented index
A  out  4  encoded index of the granted request
V  out  1  A is valid and held stable
PEND  out  16  registered pending-request vector P

Behaviour:
- Reset (async, RST=1): P=0, A=0, V=0, PTR=0, state=IDLE. Outputs are 0 while RST is high.
- Pending capture, every edge:
  - P_next = (P & ~G) | (R & {16{E}}).
  - G is the one-hot of A when state=BUSY and ACK=1; otherwise G=0.
  - Set dominates clear: if R[A] is high in the ack cycle, bit A stays pending.
- FSM state IDLE (V=0):
  - If E=1 and P!=0: select winner W from registered P, A<=W, V<=1, go to BUSY.
  - Else: remain in IDLE; A holds its last value.
- FSM state BUSY (V=1):
  - A and V are held until ACK=1.
  - On ACK: V<=0, clear P[A], go to IDLE.
  - If ROUND_ROBIN=1, PTR<=A+1 (mod 16, 4-bit wrap).
- Selection:
  - Fixed priority: W = highest set index of P.
  - Round robin: W = first set index scanning PTR, PTR+1, ..., 15, 0, ..., PTR-1.
  - PTR is unused when ROUND_ROBIN=0.
- Latency and throughput:
  - A request sampled at edge k appears in PEND after edge k.
  - V rises after edge k+1 if the block was idle.
  - Minimum 2 cycles per grant (one IDLE bubble after each ACK).
- Boundary conditions:
  - ACK while V=0 is ignored.
  - E dropping while BUSY does not abort: the current grant completes on ACK. No new grant is issued while E=0, and R is not captured while E=0.
  - Requests arriving while BUSY are captured into P. They do not change A until the next IDLE selection.
  - PTR wraps from 15 to 0. Grant at A=15 with ACK gives PTR=0.
  - All 16 bits pending: P is drained one bit per grant. No bit is lost, and no bit is granted twice unless re-requested.
  - RST asserted mid-BUSY: immediately V=0, P=0, PTR=0. A pending ACK is lost.

Test Plan:
- Reset, then pulse R=16'h0010 for 1 cycle with E=1 -> PEND=16'h0010 after edge 1; V=1, A=4 after edge 2; hold ACK low 5 cycles -> A=4 stable; ACK 1 cycle -> V=0, PEND=0.
- ROUND_ROBIN=0, R=16'h8101 held 1 cycle, ACK each grant -> grant order A=15, 8, 0, each separated by one V=0 cycle; PEND ends at 0.
- ROUND_ROBIN=1, PTR=0, R=16'hFFFF pulsed once, ACK immediately each grant -> A=0,1,...,15 in order; after A=15 is acked, PTR=0 and PEND=0.
- ROUND_ROBIN=1, grant A=15 acked, then R=16'h0005 -> next grant A=0 (wrap), then A=2.
- E=0 with R=16'h0002 held 3 cycles -> PEND=0, V=0; raise E while R stays high -> A=1, V=1 two edges later.
- During BUSY with A=3, hold R[3]=1 through the ACK cycle -> PEND[3] stays 1 and A=3 is re-granted after the bubble. Assert RST mid-BUSY -> V=0, PEND=0 asynchronously.
